freq_divider_ctrl: RTL and testbench

//  Configuration sequencer for a bank of N_CH freq_divider channels in the multiplexed-counter block.

---
 rtl/freq_div_ctrl_pkg.sv | 17 +
 rtl/freq_div_sync_edge.sv | 43 ++++
 rtl/freq_divider_ctrl.sv | 175 +++++++++++++++++
 tb/tb_freq_divider_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_ctrl_pkg.sv
// Shared types and widths for the freq_divider configuration sequencer.
// Widths here match the freq_divider channel instances.
package freq_div_ctrl_pkg;

  localparam int CFG_AW      = 3;
  localparam int CFG_DW      = 32;
  localparam int CFG_DEF_DIV = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_APPLY,
    ST_PULSE
  } state_e;

endpackage

// File: rtl/freq_div_sync_edge.sv
// Rising-edge detector on sync_evt plus saturating WAIT_SYNC timeout counter.
// Ports: evt_i event, arm_i clears counter, wait_i counts; edge_o, timeout_o.
module freq_div_sync_edge #(
  parameter int SYNC_TO = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic evt_i,
  input  logic arm_i,
  input  logic wait_i,
  output logic edge_o,
  output logic timeout_o
);

  localparam int TW = $clog2(SYNC_TO + 1);

  logic          evt_q;
  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (arm_i) begin
      cnt_d = '0;
    end else if (wait_i && cnt_q != TW'(SYNC_TO)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      evt_q <= evt_i;
      cnt_q <= cnt_d;
    end
  end

  assign edge_o    = evt_i & ~evt_q;
  // cnt_q equals the number of WAIT cycles already spent
  assign timeout_o = wait_i & (cnt_q == TW'(SYNC_TO - 1));

endmodule

// File: rtl/freq_divider_ctrl.sv
// Configuration sequencer: shadow ratio writes, atomic masked commit with
// optional sync alignment/timeout, and per-channel divider reset pulses.
// Ports: cfg_* write port, commit_* control, sync_*, div_data/div_rst out.
module freq_divider_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int N_CH    = 6,
  parameter int AW      = CFG_AW,
  parameter int DW      = CFG_DW,
  parameter int RST_CYC = 2,
  parameter int SYNC_TO = 1024,
  parameter int DEF_DIV = CFG_DEF_DIV
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [AW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  output logic           cfg_err,
  input  logic           commit_req,
  input  logic [N_CH-1:0] commit_mask,
  input  logic           sync_en,
  input  logic           sync_evt,
  output logic [N_CH*DW-1:0] div_data,
  output logic [N_CH-1:0] div_rst,
  output logic           busy,
  output logic           commit_done,
  output logic           commit_err
);

  localparam int PW = $clog2(RST_CYC + 1);
  localparam logic [AW:0] N_CH_W = (AW+1)'(N_CH);

  state_e          state_q, state_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] div_rst_q, div_rst_d;
  logic            done_q, done_d;
  logic            cerr_q, cerr_d;
  logic            cfg_err_q, cfg_err_d;
  logic [DW-1:0]   shadow_q [N_CH];
  logic [DW-1:0]   active_q [N_CH];

  logic wr_en, ch_ok, arm, apply;
  logic sync_edge, sync_to;

  assign cfg_ready = (state_q == ST_IDLE) & ~commit_req;
  assign wr_en     = cfg_valid & cfg_ready;
  assign ch_ok     = {1'b0, cfg_ch} < N_CH_W;

  freq_div_sync_edge #(
    .SYNC_TO (SYNC_TO)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .evt_i     (sync_evt),
    .arm_i     (arm),
    .wait_i    (state_q == ST_WAIT_SYNC),
    .edge_o    (sync_edge),
    .timeout_o (sync_to)
  );

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    mask_d    = mask_q;
    div_rst_d = div_rst_q;
    done_d    = 1'b0;
    cerr_d    = 1'b0;
    cfg_err_d = wr_en & ~ch_ok;
    arm       = 1'b0;
    apply     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (pcnt_q == PW'(RST_CYC - 1)) begin
          state_d   = ST_IDLE;
          div_rst_d = '0;
          pcnt_d    = '0;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      ST_IDLE: begin
        if (commit_req) begin
          if (commit_mask == '0) begin
            done_d = 1'b1;
          end else begin
            mask_d = commit_mask;
            if (sync_en) begin
              arm     = 1'b1;
              state_d = ST_WAIT_SYNC;
            end else begin
              state_d = ST_APPLY;
            end
          end
        end
      end
      ST_WAIT_SYNC: begin
        // an edge coincident with timeout still commits
        if (sync_edge) begin
          state_d = ST_APPLY;
        end else if (sync_to) begin
          state_d = ST_IDLE;
          cerr_d  = 1'b1;
        end
      end
      ST_APPLY: begin
        apply     = 1'b1;
        div_rst_d = div_rst_q | mask_q;
        pcnt_d    = '0;
        state_d   = ST_PULSE;
      end
      ST_PULSE: begin
        if (pcnt_q == PW'(RST_CYC - 1)) begin
          div_rst_d = div_rst_q & ~mask_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      pcnt_q    <= '0;
      mask_q    <= '0;
      div_rst_q <= '1;
      done_q    <= 1'b0;
      cerr_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      mask_q    <= mask_d;
      div_rst_q <= div_rst_d;
      done_q    <= done_d;
      cerr_q    <= cerr_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= DW'(DEF_DIV);
        active_q[i] <= DW'(DEF_DIV);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_en && ch_ok && cfg_ch == AW'(i)) begin
          shadow_q[i] <= cfg_div;
        end
        if (apply && mask_q[i]) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_data
    assign div_data[g*DW +: DW] = active_q[g];
  end

  assign div_rst     = div_rst_q;
  assign busy        = (state_q != ST_IDLE);
  assign commit_done = done_q;
  assign commit_err  = cerr_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_freq_divider_ctrl.sv
// Self-checking bench for freq_divider_ctrl.
// Scoreboard of expected commit outcomes plus a shadow/active ratio model.
module tb_freq_divider_ctrl;

  localparam int N  = 6;
  localparam int AW = 3;
  localparam int DW = 32;

  typedef struct {
    bit              is_err;
    logic [N*DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [AW-1:0]   cfg_ch;
  logic [DW-1:0]   cfg_div;
  logic            cfg_err;
  logic            commit_req;
  logic [N-1:0]    commit_mask;
  logic            sync_en;
  logic            sync_evt;
  logic [N*DW-1:0] div_data;
  logic [N-1:0]    div_rst;
  logic            busy;
  logic            commit_done;
  logic            commit_err;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t        sb[$];
  logic [DW-1:0] sh [N];
  logic [DW-1:0] ac [N];

  always #5 clk = ~clk;

  freq_divider_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_err     (cfg_err),
    .commit_req  (commit_req),
    .commit_mask (commit_mask),
    .sync_en     (sync_en),
    .sync_evt    (sync_evt),
    .div_data    (div_data),
    .div_rst     (div_rst),
    .busy        (busy),
    .commit_done (commit_done),
    .commit_err  (commit_err)
  );

  function automatic logic [N*DW-1:0] pack();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = ac[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh[i] = 32'd2;
      ac[i] = 32'd2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input logic [DW-1:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = AW'(ch);
    cfg_div   = d;
    tick();
    cfg_valid = 1'b0;
    if (ch < N) sh[ch] = d;
  endtask

  task automatic do_commit(input logic [N-1:0] m, input bit s, input bit fail);
    exp_t e;
    commit_req  = 1'b1;
    commit_mask = m;
    sync_en     = s;
    if (!fail)
      for (int i = 0; i < N; i++) if (m[i]) ac[i] = sh[i];
    e.is_err = fail;
    e.data   = pack();
    sb.push_back(e);
    tick();
    commit_req = 1'b0;
    sync_en    = 1'b0;
  endtask

  task automatic wait_result(input int max, output bit got_done,
                             output bit got_err, output int n);
    n = 0;
    while (!commit_done && !commit_err && n < max) begin
      tick();
      n++;
    end
    got_done = commit_done;
    got_err  = commit_err;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++;
    if (div_rst !== 6'h3F || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: rst=%h busy=%b rdy=%b want 3f/1/0", div_rst, busy, cfg_ready);
    end
    n_cmp++;
    if (div_data !== pack() || commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h done=%b want %h", div_data, commit_done, pack());
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (div_rst !== 6'h3F || busy !== 1'b1 || commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL init_hold: rst=%h busy=%b done=%b want 3f/1/0", div_rst, busy, commit_done);
    end
    tick();
    n_cmp++;
    if (div_rst !== 6'h00 || busy !== 1'b0 || cfg_ready !== 1'b1 || commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL init_end: rst=%h busy=%b rdy=%b done=%b want 00/0/1/0",
               div_rst, busy, cfg_ready, commit_done);
    end
  endtask

  task automatic test_commit_nosync();
    exp_t e;
    do_write(3, 32'd100);
    do_commit(6'b001000, 1'b0, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || div_data[3*DW +: DW] !== 32'd2) begin
      n_fail++;
      $display("FAIL e0_state: busy=%b ch3=%0d want 1/2", busy, div_data[3*DW +: DW]);
    end
    tick();
    n_cmp++;
    if (div_data[3*DW +: DW] !== 32'd100 || div_rst !== 6'b001000 || commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL e0p1: ch3=%0d rst=%h done=%b want 100/08/0",
               div_data[3*DW +: DW], div_rst, commit_done);
    end
    tick();
    n_cmp++;
    if (div_rst !== 6'b001000 || commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL e0p2: rst=%h done=%b want 08/0", div_rst, commit_done);
    end
    tick();
    n_cmp++;
    if (div_rst !== 6'b000000 || commit_done !== 1'b1) begin
      n_fail++;
      $display("FAIL e0p3: rst=%h done=%b want 00/1", div_rst, commit_done);
    end
    e = sb.pop_front();
    n_cmp++;
    if (e.is_err || div_data !== e.data) begin
      n_fail++;
      $display("FAIL commit_data: got %h want %h err=%b", div_data, e.data, e.is_err);
    end
    tick();
    n_cmp++;
    if (commit_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b want 0/0", commit_done, busy);
    end
  endtask

  task automatic test_sync();
    exp_t e;
    bit gd, ge;
    int n;
    do_write(0, 32'd7);
    do_commit(6'b000001, 1'b1, 1'b1);
    wait_result(1100, gd, ge, n);
    e = sb.pop_front();
    n_cmp++;
    if (ge !== e.is_err || gd !== 1'b0 || n != 1024) begin
      n_fail++;
      $display("FAIL sync_timeout: err=%b done=%b cyc=%0d want 1/0/1024", ge, gd, n);
    end
    n_cmp++;
    if (div_data !== e.data || div_rst !== 6'h00) begin
      n_fail++;
      $display("FAIL timeout_data: got %h rst=%h want %h", div_data, div_rst, e.data);
    end
    tick();
    // edge lands on the final timeout cycle
    do_commit(6'b000001, 1'b1, 1'b0);
    repeat (1023) tick();
    sync_evt = 1'b1;
    tick();
    n_cmp++;
    if (commit_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_tie: err=%b busy=%b want 0/1", commit_err, busy);
    end
    sync_evt = 1'b0;
    wait_result(10, gd, ge, n);
    e = sb.pop_front();
    n_cmp++;
    if (gd !== 1'b1 || ge !== e.is_err || div_data !== e.data) begin
      n_fail++;
      $display("FAIL tie_commit: done=%b err=%b got %h want %h", gd, ge, div_data, e.data);
    end
    tick();
    do_write(1, 32'd55);
    do_commit(6'b000010, 1'b1, 1'b0);
    repeat (50) tick();
    n_cmp++;
    if (busy !== 1'b1 || div_data[DW +: DW] !== 32'd2) begin
      n_fail++;
      $display("FAIL sync_wait: busy=%b ch1=%0d want 1/2", busy, div_data[DW +: DW]);
    end
    sync_evt = 1'b1;
    wait_result(10, gd, ge, n);
    sync_evt = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (gd !== 1'b1 || n != 1 + 2 + 1 - 1 + 1 || div_data !== e.data) begin
      n_fail++;
      $display("FAIL sync_commit: done=%b cyc=%0d got %h want 1/4 %h", gd, n, div_data, e.data);
    end
    tick();
  endtask

  task automatic test_cfg_port();
    exp_t e;
    bit gd, ge;
    int n;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd6;
    cfg_div   = 32'd999;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_hi: got %b want 1", cfg_err);
    end
    tick();
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_lo: got %b want 0", cfg_err);
    end
    cfg_valid   = 1'b1;
    cfg_ch      = 3'd2;
    cfg_div     = 32'd77;
    commit_req  = 1'b1;
    commit_mask = '0;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_ready: got %b want 0", cfg_ready);
    end
    e.is_err = 1'b0;
    e.data   = pack();
    sb.push_back(e);
    tick();
    cfg_valid  = 1'b0;
    commit_req = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (commit_done !== 1'b1 || cfg_err !== 1'b0 || div_data !== e.data) begin
      n_fail++;
      $display("FAIL tie_commit0: done=%b cerr=%b got %h", commit_done, cfg_err, div_data);
    end
    tick();
    do_commit(6'h3F, 1'b0, 1'b0);
    wait_result(10, gd, ge, n);
    e = sb.pop_front();
    n_cmp++;
    if (gd !== 1'b1 || div_data !== e.data) begin
      n_fail++;
      $display("FAIL shadow_all: done=%b got %h want %h", gd, div_data, e.data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int dones;
    do_commit(6'b000000, 1'b0, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (commit_done !== 1'b1 || div_rst !== 6'h00 || busy !== 1'b0 || div_data !== e.data) begin
      n_fail++;
      $display("FAIL mask0: done=%b rst=%h busy=%b want 1/00/0", commit_done, div_rst, busy);
    end
    tick();
    do_write(2, 32'd300);
    do_commit(6'b000100, 1'b0, 1'b0);
    commit_req  = 1'b1;
    commit_mask = 6'h3F;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ready: rdy=%b busy=%b want 0/1", cfg_ready, busy);
    end
    tick();
    tick();
    commit_req = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (commit_done) dones++;
    end
    e = sb.pop_front();
    n_cmp++;
    if (dones != 1 || div_data !== e.data) begin
      n_fail++;
      $display("FAIL busy_ignore: dones=%0d got %h want 1 %h", dones, div_data, e.data);
    end
  endtask

  task automatic test_mid_reset();
    do_write(4, 32'd9);
    do_commit(6'b010000, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (div_data[4*DW +: DW] !== 32'd9 || div_rst !== 6'b010000) begin
      n_fail++;
      $display("FAIL pre_reset: ch4=%0d rst=%h want 9/10", div_data[4*DW +: DW], div_rst);
    end
    #1 rst = 1'b0;
    #1;
    sb.delete();
    model_reset();
    n_cmp++;
    if (div_rst !== 6'h3F || busy !== 1'b1 || div_data !== pack() || commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rst=%h busy=%b got %h", div_rst, busy, div_data);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (div_rst !== 6'h00 || busy !== 1'b0 || commit_done !== 1'b0 || div_data !== pack()) begin
      n_fail++;
      $display("FAIL post_reset: rst=%h busy=%b done=%b", div_rst, busy, commit_done);
    end
  endtask

  initial begin
    rst         = 1'b0;
    cfg_valid   = 1'b0;
    cfg_ch      = '0;
    cfg_div     = '0;
    commit_req  = 1'b0;
    commit_mask = '0;
    sync_en     = 1'b0;
    sync_evt    = 1'b0;
    model_reset();
    test_reset();
    test_commit_nosync();
    test_sync();
    test_cfg_port();
    test_back_to_back();
    test_mid_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
